// File: rtl/aclock_pkg.sv
// Shared types and constants for the aclock button sequencer and its BCD
// arithmetic helper.
package aclock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT_H,
    ST_EDIT_M,
    ST_COMMIT
  } state_t;

  typedef enum logic [1:0] {
    FIELD_NONE    = 2'b00,
    FIELD_HOURS   = 2'b01,
    FIELD_MINUTES = 2'b10
  } edit_field_t;

  typedef enum logic [1:0] {
    OP_INC_HOUR,
    OP_INC_MIN,
    OP_ADD_MIN
  } inc_op_t;

  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_time_t;

  // Hours +1 with wrap; anything at or past 23 (or not valid BCD) restarts at 00.
  function automatic bcd_time_t hour_next(input bcd_time_t t);
    bcd_time_t  r;
    logic [5:0] hv;
    r  = t;
    hv = {4'b0, t.h1} * 6'd10 + {2'b0, t.h0};
    if (t.h0 > 4'd9 || hv >= 6'(HR_MAX)) begin
      r.h1 = 2'd0;
      r.h0 = 4'd0;
    end else if (t.h0 == 4'd9) begin
      r.h1 = t.h1 + 2'd1;
      r.h0 = 4'd0;
    end else begin
      r.h0 = t.h0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_inc.sv
// Combinational BCD time arithmetic: hour +1, minute +1 (no carry), or
// minute +N with carry into hours.
import aclock_pkg::*;

module bcd_time_inc (
  input  bcd_time_t  t,
  input  inc_op_t    op,
  input  logic [3:0] add_min,
  output bcd_time_t  y
);

  logic [4:0] m0_sum;
  logic [4:0] m0_adj;
  bcd_time_t  hr;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch can be inferred.
  always_comb begin
    y      = t;
    hr     = hour_next(t);
    m0_sum = {1'b0, t.m0} + {1'b0, add_min};
    m0_adj = m0_sum - 5'd10;
    case (op)
      OP_INC_HOUR: y = hr;
      OP_INC_MIN: begin
        if (t.m0 >= 4'(MIN_MAX % 10)) begin
          y.m0 = 4'd0;
          y.m1 = (t.m1 >= 4'(MIN_MAX / 10)) ? 4'd0 : t.m1 + 4'd1;
        end else begin
          y.m0 = t.m0 + 4'd1;
        end
      end
      OP_ADD_MIN: begin
        if (m0_sum >= 5'd10) begin
          y.m0 = m0_adj[3:0];
          if (t.m1 >= 4'(MIN_MAX / 10)) begin
            y.m1 = 4'd0;
            y.h1 = hr.h1;
            y.h0 = hr.h0;
          end else begin
            y.m1 = t.m1 + 4'd1;
          end
        end else begin
          y.m0 = m0_sum[3:0];
        end
      end
      default: y = t;
    endcase
  end

endmodule

// File: rtl/aclock_set_ctrl.sv
// Button sequencer in front of aclock: time/alarm edit, arm flag and STOP_al
// scheduling. Define ACLOCK_SNOOZE_EN to add the snooze_btn input and logic.
import aclock_pkg::*;

module aclock_set_ctrl #(
  parameter int TIMEOUT_CYC   = 30,
  parameter int ALARM_MAX_CYC = 60,
  parameter int SNOOZE_MIN    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       sel_alarm,
  input  logic       al_toggle_btn,
  input  logic       stop_btn,
`ifdef ACLOCK_SNOOZE_EN
  input  logic       snooze_btn,
`endif
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  input  logic       Alarm,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       AL_ON,
  output logic       STOP_al,
  output logic       edit_active,
  output logic [1:0] edit_field
);

  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int RING_W = $clog2(ALARM_MAX_CYC + 1);

  state_t           state_q, state_d;
  logic             sel_q;
  bcd_time_t        edit_q, shadow_q, hold_q;
  bcd_time_t        cur_t, edit_inc, load_t, snz_t;
  logic [TMO_W-1:0] tmo_q;
  logic [RING_W-1:0] ring_q;
  logic             al_on_q, stop_q;
  logic             any_btn, in_edit, commit, timeout, ring_stop;
  logic             snz_load, snz_stop;

  assign cur_t = {cur_h1, cur_h0, cur_m1, cur_m0};

  bcd_time_inc u_edit_inc (
    .t       (edit_q),
    .op      ((state_q == ST_EDIT_H) ? OP_INC_HOUR : OP_INC_MIN),
    .add_min (4'd1),
    .y       (edit_inc)
  );

`ifdef ACLOCK_SNOOZE_EN
  logic snz_pend_q, snz_wait_q;

  bcd_time_inc u_snooze_add (
    .t       (cur_t),
    .op      (OP_ADD_MIN),
    .add_min (4'(SNOOZE_MIN)),
    .y       (snz_t)
  );

  assign snz_stop = snooze_btn && Alarm;
  // A commit owns the load bus for its cycle; the snooze load waits behind it.
  assign snz_load = snz_wait_q && !commit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      snz_pend_q <= 1'b0;
      snz_wait_q <= 1'b0;
    end else begin
      snz_pend_q <= snz_stop;
      snz_wait_q <= snz_pend_q || (snz_wait_q && commit);
    end
  end
`else
  assign snz_stop = 1'b0;
  assign snz_load = 1'b0;
  assign snz_t    = '0;
`endif

  assign any_btn = mode_btn | inc_btn | al_toggle_btn | stop_btn | snz_stop;
  assign in_edit = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M);
  assign commit  = (state_q == ST_COMMIT);
  assign timeout = in_edit && !any_btn && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign ring_stop = Alarm && (ring_q == RING_W'(ALARM_MAX_CYC - 2));

  always_comb begin
    state_d     = state_q;
    edit_active = 1'b0;
    edit_field  = FIELD_NONE;
    case (state_q)
      ST_IDLE: if (mode_btn) state_d = ST_EDIT_H;
      ST_EDIT_H: begin
        edit_active = 1'b1;
        edit_field  = FIELD_HOURS;
        if (mode_btn)     state_d = ST_EDIT_M;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_EDIT_M: begin
        edit_active = 1'b1;
        edit_field  = FIELD_MINUTES;
        if (mode_btn)     state_d = ST_COMMIT;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign load_t   = commit ? edit_q : (snz_load ? snz_t : hold_q);
  assign H_in1    = load_t.h1;
  assign H_in0    = load_t.h0;
  assign M_in1    = load_t.m1;
  assign M_in0    = load_t.m0;
  assign LD_time  = commit && !sel_q;
  assign LD_alarm = (commit && sel_q) || snz_load;
  assign AL_ON    = al_on_q;
  assign STOP_al  = stop_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the edit and shadow registers are reset too, since an alarm
      // edit seeds from the shadow and must start from a known 00:00.
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      edit_q   <= '0;
      shadow_q <= '0;
      hold_q   <= '0;
      tmo_q    <= '0;
      ring_q   <= '0;
      al_on_q  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= load_t;
      if (state_q == ST_IDLE && mode_btn) begin
        sel_q  <= sel_alarm;
        edit_q <= sel_alarm ? shadow_q : cur_t;
      end else if (in_edit && inc_btn && !mode_btn) begin
        edit_q <= edit_inc;
      end
      if (commit && sel_q) shadow_q <= edit_q;

      tmo_q <= (!in_edit || any_btn) ? '0 : tmo_q + TMO_W'(1);

      // Saturate past the trigger point so one ring yields a single auto-stop.
      if (!Alarm)                                  ring_q <= '0;
      else if (ring_q != RING_W'(ALARM_MAX_CYC))   ring_q <= ring_q + RING_W'(1);

      al_on_q <= al_on_q ^ al_toggle_btn;
      stop_q  <= (stop_btn && Alarm) || (al_toggle_btn && al_on_q && Alarm) ||
                 ring_stop || snz_stop;
    end
  end

endmodule

// File: tb/tb_aclock_set_ctrl.sv
// Self-checking bench for aclock_set_ctrl with a minutes-of-day reference model.
`timescale 1ns/1ps

module tb_aclock_set_ctrl;

  localparam int TIMEOUT_CYC   = 30;
  localparam int ALARM_MAX_CYC = 60;
  localparam int SNOOZE_MIN    = 5;

  logic       clk = 1'b0;
  logic       reset, mode_btn, inc_btn, sel_alarm, al_toggle_btn, stop_btn, snooze_btn;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0, cur_m1, cur_m0;
  logic       Alarm;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, AL_ON, STOP_al, edit_active;
  logic [1:0] edit_field;

  int errors = 0;
  int checks = 0;
  int n_lt = 0, n_la = 0, n_stop = 0, n_both = 0;
  int sh_h = 0, sh_m = 0;

  aclock_set_ctrl #(
    .TIMEOUT_CYC(TIMEOUT_CYC), .ALARM_MAX_CYC(ALARM_MAX_CYC), .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .sel_alarm(sel_alarm), .al_toggle_btn(al_toggle_btn), .stop_btn(stop_btn),
`ifdef ACLOCK_SNOOZE_EN
    .snooze_btn(snooze_btn),
`endif
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0), .Alarm(Alarm),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_ON(AL_ON), .STOP_al(STOP_al),
    .edit_active(edit_active), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (LD_time)             n_lt++;
    if (LD_alarm)            n_la++;
    if (STOP_al)             n_stop++;
    if (LD_time && LD_alarm) n_both++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] bcd(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [13:0] out_val();
    return {H_in1, H_in0, M_in1, M_in0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i, input logic t, input logic s,
                       input logic z);
    mode_btn = m; inc_btn = i; al_toggle_btn = t; stop_btn = s; snooze_btn = z;
    tick();
    mode_btn = 0; inc_btn = 0; al_toggle_btn = 0; stop_btn = 0; snooze_btn = 0;
  endtask

  task automatic set_cur(input int h, input int m);
    {cur_h1, cur_h0, cur_m1, cur_m0} = bcd(h, m);
  endtask

  // Full edit; returns the bus and strobes seen in the COMMIT cycle.
  task automatic run_edit(input logic sel, input int nh, input int nm,
                          output logic [13:0] v, output logic lt, output logic la);
    sel_alarm = sel;
    press(1, 0, 0, 0, 0);
    sel_alarm = 0;
    repeat (nh) press(0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    repeat (nm) press(0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    v = out_val(); lt = LD_time; la = LD_alarm;
    tick();
  endtask

  task automatic test_reset();
    reset = 0;
    tick(); tick();
    reset = 1;
    sh_h = 0; sh_m = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({out_val(), LD_time, LD_alarm, AL_ON, STOP_al, edit_active, edit_field} !== 20'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got bus=%h lt=%b la=%b on=%b stop=%b ea=%b ef=%b, want all 0",
                 k, out_val(), LD_time, LD_alarm, AL_ON, STOP_al, edit_active, edit_field);
      end
      tick();
    end
  endtask

  task automatic test_time_edit();
    logic [13:0] v; logic lt, la; int lt0, la0;
    set_cur(10, 19);
    lt0 = n_lt; la0 = n_la;
    sel_alarm = 0;
    press(1, 0, 0, 0, 0);
    checks++;
    if (edit_field !== 2'b01 || edit_active !== 1'b1) begin
      errors++; $display("FAIL edit_field_hours: got %b/%b want 01/1", edit_field, edit_active);
    end
    repeat (3) press(0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    checks++;
    if (edit_field !== 2'b10) begin
      errors++; $display("FAIL edit_field_minutes: got %b want 10", edit_field);
    end
    repeat (2) press(0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    v = out_val(); lt = LD_time; la = LD_alarm;
    tick();
    checks++;
    if (v !== bcd(13, 21) || lt !== 1'b1 || la !== 1'b0) begin
      errors++; $display("FAIL time_commit: got %h lt=%b la=%b want %h lt=1 la=0", v, lt, la, bcd(13, 21));
    end
    checks++;
    if (out_val() !== bcd(13, 21) || LD_time !== 1'b0 || edit_active !== 1'b0) begin
      errors++; $display("FAIL time_hold: got %h lt=%b ea=%b want %h lt=0 ea=0", out_val(), LD_time, edit_active, bcd(13, 21));
    end
    checks++;
    if (n_lt - lt0 != 1 || n_la - la0 != 0) begin
      errors++; $display("FAIL time_strobe_count: got lt=%0d la=%0d want 1 0", n_lt - lt0, n_la - la0);
    end
  endtask

  task automatic test_wrap();
    logic [13:0] v; logic lt, la;
    run_edit(1, (23 - sh_h + 24) % 24, (59 - sh_m + 60) % 60, v, lt, la);
    sh_h = 23; sh_m = 59;
    checks++;
    if (v !== bcd(23, 59) || la !== 1'b1 || lt !== 1'b0) begin
      errors++; $display("FAIL alarm_set_2359: got %h la=%b lt=%b want %h la=1 lt=0", v, la, lt, bcd(23, 59));
    end
    run_edit(1, 1, 1, v, lt, la);
    sh_h = 0; sh_m = 0;
    checks++;
    if (v !== bcd(0, 0) || la !== 1'b1) begin
      errors++; $display("FAIL wrap_commit: got %h la=%b want %h la=1", v, la, bcd(0, 0));
    end
    run_edit(1, 0, 0, v, lt, la);
    checks++;
    if (v !== bcd(0, 0) || la !== 1'b1) begin
      errors++; $display("FAIL shadow_reseed: got %h la=%b want %h la=1", v, la, bcd(0, 0));
    end
  endtask

  task automatic test_invalid_seed();
    logic [13:0] v; logic lt, la;
    {cur_h1, cur_h0, cur_m1, cur_m0} = {2'd2, 4'd7, 4'd0, 4'd5};
    run_edit(0, 1, 0, v, lt, la);
    checks++;
    if (v !== bcd(0, 5) || lt !== 1'b1) begin
      errors++; $display("FAIL invalid_hour_seed: got %h lt=%b want %h lt=1", v, lt, bcd(0, 5));
    end
  endtask

  task automatic test_timeout();
    int lt0, la0;
    lt0 = n_lt; la0 = n_la;
    set_cur(8, 30);
    sel_alarm = 0;
    press(1, 0, 0, 0, 0);
    repeat (TIMEOUT_CYC - 1) tick();
    checks++;
    if (edit_active !== 1'b1) begin
      errors++; $display("FAIL timeout_early: got edit_active=%b want 1", edit_active);
    end
    tick();
    checks++;
    if (edit_active !== 1'b0 || edit_field !== 2'b00) begin
      errors++; $display("FAIL timeout_idle: got ea=%b ef=%b want 0 00", edit_active, edit_field);
    end
    repeat (2) tick();
    checks++;
    if (n_lt != lt0 || n_la != la0) begin
      errors++; $display("FAIL timeout_no_strobe: got lt=%0d la=%0d new strobes want 0", n_lt - lt0, n_la - la0);
    end
  endtask

  task automatic test_mode_inc_same_cycle();
    logic [13:0] v;
    set_cur(10, 19);
    sel_alarm = 0;
    press(1, 0, 0, 0, 0);
    press(1, 1, 0, 0, 0);
    checks++;
    if (edit_field !== 2'b10) begin
      errors++; $display("FAIL mode_inc_field: got %b want 10", edit_field);
    end
    press(1, 0, 0, 0, 0);
    v = out_val();
    checks++;
    if (v !== bcd(10, 19) || LD_time !== 1'b1) begin
      errors++; $display("FAIL mode_inc_value: got %h lt=%b want %h lt=1", v, LD_time, bcd(10, 19));
    end
    tick();
  endtask

  task automatic test_reset_mid_edit();
    int lt0, la0;
    lt0 = n_lt; la0 = n_la;
    sel_alarm = 1;
    press(1, 0, 0, 0, 0);
    sel_alarm = 0;
    press(0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    reset = 0;
    tick();
    reset = 1;
    sh_h = 0; sh_m = 0;
    repeat (3) tick();
    checks++;
    if (edit_active !== 1'b0 || n_lt != lt0 || n_la != la0 || AL_ON !== 1'b0) begin
      errors++; $display("FAIL reset_mid_edit: got ea=%b strobes=%0d on=%b want 0 0 0",
                         edit_active, (n_lt - lt0) + (n_la - la0), AL_ON);
    end
  endtask

  task automatic test_stop_btn();
    press(0, 0, 1, 0, 0);
    checks++;
    if (AL_ON !== 1'b1) begin
      errors++; $display("FAIL arm: got AL_ON=%b want 1", AL_ON);
    end
    Alarm = 1;
    for (int c = 0; c <= 5; c++) begin
      checks++;
      if (STOP_al !== (c == 4)) begin
        errors++; $display("FAIL stop_btn_cycle%0d: got %b want %b", c, STOP_al, c == 4);
      end
      stop_btn = (c == 3);
      tick();
      stop_btn = 0;
    end
    Alarm = 0;
    repeat (2) tick();
    press(0, 0, 0, 1, 0);
    checks++;
    if (STOP_al !== 1'b0) begin
      errors++; $display("FAIL stop_ignored: got %b want 0", STOP_al);
    end
  endtask

  task automatic test_ring_timeout();
    int s0;
    s0 = n_stop;
    Alarm = 1;
    for (int c = 0; c <= ALARM_MAX_CYC + 4; c++) begin
      checks++;
      if (STOP_al !== (c == ALARM_MAX_CYC - 1)) begin
        errors++; $display("FAIL ring_cycle%0d: got %b want %b", c, STOP_al, c == ALARM_MAX_CYC - 1);
      end
      tick();
    end
    Alarm = 0;
    tick();
    checks++;
    if (n_stop - s0 != 1) begin
      errors++; $display("FAIL ring_single: got %0d pulses want 1", n_stop - s0);
    end
  endtask

  task automatic test_toggle_while_ringing();
    int s0;
    Alarm = 1;
    tick();
    s0 = n_stop;
    press(0, 0, 1, 1, 0);
    checks++;
    if (AL_ON !== 1'b0 || STOP_al !== 1'b1) begin
      errors++; $display("FAIL toggle_stop: got on=%b stop=%b want 0 1", AL_ON, STOP_al);
    end
    tick();
    checks++;
    if (STOP_al !== 1'b0 || n_stop - s0 != 1) begin
      errors++; $display("FAIL toggle_single: got stop=%b pulses=%0d want 0 1", STOP_al, n_stop - s0);
    end
    press(0, 0, 1, 0, 0);
    checks++;
    if (AL_ON !== 1'b1 || STOP_al !== 1'b0) begin
      errors++; $display("FAIL rearm_ringing: got on=%b stop=%b want 1 0", AL_ON, STOP_al);
    end
    Alarm = 0;
    repeat (2) tick();
  endtask

  task automatic test_random_edits();
    logic [13:0] v; logic lt, la;
    int ch, cm, nh, nm, eh, em;
    logic sel;
    for (int it = 0; it < 8; it++) begin
      ch = $urandom_range(0, 23); cm = $urandom_range(0, 59);
      nh = $urandom_range(0, 30); nm = $urandom_range(0, 70);
      sel = 1'($urandom_range(0, 1));
      set_cur(ch, cm);
      eh = ((sel ? sh_h : ch) + nh) % 24;
      em = ((sel ? sh_m : cm) + nm) % 60;
      run_edit(sel, nh, nm, v, lt, la);
      if (sel) begin sh_h = eh; sh_m = em; end
      checks++;
      if (v !== bcd(eh, em) || lt !== !sel || la !== sel) begin
        errors++; $display("FAIL random_edit%0d: got %h lt=%b la=%b want %h lt=%b la=%b",
                           it, v, lt, la, bcd(eh, em), !sel, sel);
      end
    end
    checks++;
    if (n_both != 0) begin
      errors++; $display("FAIL ld_exclusive: got %0d overlapping cycles want 0", n_both);
    end
  endtask

`ifdef ACLOCK_SNOOZE_EN
  task automatic test_snooze();
    logic [13:0] v; logic lt, la;
    int ch, cm, tot;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin ch = 23; cm = 57; end
      else begin ch = $urandom_range(0, 23); cm = $urandom_range(0, 59); end
      tot = (ch * 60 + cm + SNOOZE_MIN) % 1440;
      set_cur(ch, cm);
      Alarm = 1;
      press(0, 0, 0, 0, 1);
      checks++;
      if (STOP_al !== 1'b1 || LD_alarm !== 1'b0) begin
        errors++; $display("FAIL snooze_stop%0d: got stop=%b la=%b want 1 0", it, STOP_al, LD_alarm);
      end
      tick();
      checks++;
      if (LD_alarm !== 1'b1 || out_val() !== bcd(tot / 60, tot % 60) || LD_time !== 1'b0) begin
        errors++; $display("FAIL snooze_load%0d: got la=%b %h want la=1 %h", it, LD_alarm, out_val(), bcd(tot / 60, tot % 60));
      end
      Alarm = 0;
      tick();
      checks++;
      if (LD_alarm !== 1'b0) begin
        errors++; $display("FAIL snooze_single%0d: got la=%b want 0", it, LD_alarm);
      end
      repeat (2) tick();
    end
    run_edit(1, 0, 0, v, lt, la);
    checks++;
    if (v !== bcd(sh_h, sh_m)) begin
      errors++; $display("FAIL snooze_shadow: got %h want %h", v, bcd(sh_h, sh_m));
    end
  endtask
`endif

  initial begin
    reset = 0; mode_btn = 0; inc_btn = 0; sel_alarm = 0; al_toggle_btn = 0;
    stop_btn = 0; snooze_btn = 0; Alarm = 0;
    set_cur(0, 0);
    test_reset();
    test_time_edit();
    test_wrap();
    test_invalid_seed();
    test_timeout();
    test_mode_inc_same_cycle();
    test_reset_mid_edit();
    test_stop_btn();
    test_ring_timeout();
    test_toggle_while_ringing();
    test_random_edits();
`ifdef ACLOCK_SNOOZE_EN
    test_snooze();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
